// File: rtl/dbus_timer_target.sv
// dbus_timer_target: bus-attached down-counting timer with a prescaler,
// auto-reload, and a maskable expiry interrupt.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   bus_Addr_i          byte address; [15:4] decode, [3:1] register index
//   bus_Data_i          write data, byte lanes selected by bus_stb_i
//   bus_stb_i           byte strobes ([0] -> 7:0, [1] -> 15:8)
//   bus_rd_i, bus_wr_i  request lines, held by the master until rdy is seen
//   bus_Data_o          read data (zero outside the read response cycle)
//   bus_Data_e          per-bit enable for bus_Data_o
//   bus_rdy_o           one-cycle transfer-complete strobe
//   intr_o              EXP & IE
//   inta_i              interrupt acknowledge, clears EXP
//
// Register map (index = bus_Addr_i[3:1]):
//   0 CTRL {IE, AR, EN}  1 STATUS {EXP} (write 1 clears)
//   2 RELOAD  3 COUNT  4 PRESC  5..7 read 0, writes ignored
module dbus_timer_target #(
    parameter logic [15:0] BASE = 16'hFF00,
    parameter int unsigned WAIT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] bus_Addr_i,
    input  logic [15:0] bus_Data_i,
    input  logic [1:0]  bus_stb_i,
    input  logic        bus_rd_i,
    input  logic        bus_wr_i,
    output logic [15:0] bus_Data_o,
    output logic [15:0] bus_Data_e,
    output logic        bus_rdy_o,
    output logic        intr_o,
    input  logic        inta_i
);

    localparam int unsigned DW  = 16;
    localparam int unsigned WCW = 4;
    localparam int unsigned IW  = 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_e;

    state_e           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             rdy_q, rdy_d;
    logic [DW-1:0]    data_o_q, data_o_d;
    logic [DW-1:0]    data_e_q, data_e_d;

    logic [2:0]       ctrl_q, ctrl_d;      // {IE, AR, EN}
    logic             exp_q, exp_d;
    logic [DW-1:0]    reload_q, reload_d;
    logic [DW-1:0]    count_q, count_d;
    logic [DW-1:0]    presc_q, presc_d;
    logic [DW-1:0]    pcnt_q, pcnt_d;

    logic             hit, req, sel, is_rd, wr_commit;
    logic [IW-1:0]    idx;
    logic [DW-1:0]    rdata_c;
    logic             tick, expire;
    logic             unused_addr_lsb;

    // Address decode; rd+wr together is a write, never a read
    assign hit             = (bus_Addr_i[15:4] == BASE[15:4]);
    assign req             = bus_rd_i | bus_wr_i;
    assign sel             = hit & req;
    assign is_rd           = bus_rd_i & ~bus_wr_i;
    assign idx             = bus_Addr_i[3:1];
    assign unused_addr_lsb = bus_Addr_i[0];

    // Writes take effect on the edge that ends the response cycle
    assign wr_commit = (state_q == S_RESP) && bus_wr_i && hit;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [1:0]    stb);
        merge_bytes = old_v;
        if (stb[0]) merge_bytes[7:0]  = new_v[7:0];
        if (stb[1]) merge_bytes[15:8] = new_v[15:8];
    endfunction

    // Read mux
    always_comb begin
        rdata_c = '0;
        case (idx)
            3'd0:    rdata_c = {13'b0, ctrl_q};
            3'd1:    rdata_c = {15'b0, exp_q};
            3'd2:    rdata_c = reload_q;
            3'd3:    rdata_c = count_q;
            3'd4:    rdata_c = presc_q;
            default: rdata_c = '0;
        endcase
    end

    // Bus FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Bus FSM next state; WAIT stays WAIT cycles, dropping the request aborts
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (sel) begin
                    wcnt_d  = WCW'(WAIT);
                    state_d = (WAIT == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                    if (wcnt_q == WCW'(1)) state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_HOLD;
            S_HOLD:  if (!req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs, registered so they are valid exactly during RESP
    always_comb begin
        rdy_d    = 1'b0;
        data_o_d = '0;
        data_e_d = '0;
        if (state_d == S_RESP) begin
            rdy_d = 1'b1;
            if (is_rd) begin
                data_o_d = rdata_c;
                data_e_d = '1;
            end
        end
    end

    // Timer next state; bus writes are applied after the tick so they win
    always_comb begin
        ctrl_d   = ctrl_q;
        exp_d    = exp_q;
        reload_d = reload_q;
        count_d  = count_q;
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;

        tick   = ctrl_q[0] && (pcnt_q == '0);
        expire = tick && (count_q == '0);

        if (ctrl_q[0]) pcnt_d = tick ? presc_q : pcnt_q - DW'(1);

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - DW'(1);
            end else if (ctrl_q[1]) begin
                count_d = reload_q;
            end else begin
                count_d   = '0;
                ctrl_d[0] = 1'b0;
            end
        end

        if (wr_commit) begin
            case (idx)
                3'd0:    if (bus_stb_i[0]) ctrl_d = bus_Data_i[2:0];
                3'd2:    reload_d = merge_bytes(reload_q, bus_Data_i, bus_stb_i);
                3'd3:    count_d  = merge_bytes(count_q, bus_Data_i, bus_stb_i);
                3'd4:    presc_d  = merge_bytes(presc_q, bus_Data_i, bus_stb_i);
                default: ;
            endcase
            // Restart the prescaler from the (possibly new) PRESC value
            if (idx == IW'(0) || idx == IW'(4)) pcnt_d = presc_d;
        end

        if (inta_i || (wr_commit && idx == IW'(1) && bus_stb_i[0] && bus_Data_i[0]))
            exp_d = 1'b0;
        if (expire) exp_d = 1'b1;
    end

    // Timer and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q   <= '0;
            exp_q    <= 1'b0;
            reload_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            rdy_q    <= 1'b0;
            data_o_q <= '0;
            data_e_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            exp_q    <= exp_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            rdy_q    <= rdy_d;
            data_o_q <= data_o_d;
            data_e_q <= data_e_d;
        end
    end

    assign bus_rdy_o  = rdy_q;
    assign bus_Data_o = data_o_q;
    assign bus_Data_e = data_e_q;
    assign intr_o     = exp_q & ctrl_q[2];

endmodule

// File: tb/tb_dbus_timer_target.sv
// Directed bench for dbus_timer_target: one instance with WAIT=1 and one
// with WAIT=3 sharing clock, reset, address, data and strobes.
module tb_dbus_timer_target;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr, wdata;
    logic [1:0]  stb;
    logic        rd1, wr1, rd3, wr3, inta;
    logic [15:0] dout1, de1, dout3, de3;
    logic        rdy1, intr1, rdy3, intr3;

    int checks = 0;
    int errors = 0;
    int cur    = 0;

    logic        rdy_m;
    logic [15:0] dout_m, de_m;

    always #5 clk = ~clk;

    assign rdy_m  = (cur == 1) ? rdy3  : rdy1;
    assign dout_m = (cur == 1) ? dout3 : dout1;
    assign de_m   = (cur == 1) ? de3   : de1;

    dbus_timer_target #(.BASE(16'hFF00), .WAIT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .bus_Addr_i(addr), .bus_Data_i(wdata),
        .bus_stb_i(stb), .bus_rd_i(rd1), .bus_wr_i(wr1), .bus_Data_o(dout1),
        .bus_Data_e(de1), .bus_rdy_o(rdy1), .intr_o(intr1), .inta_i(inta)
    );

    dbus_timer_target #(.BASE(16'hFF00), .WAIT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_n), .bus_Addr_i(addr), .bus_Data_i(wdata),
        .bus_stb_i(stb), .bus_rd_i(rd3), .bus_wr_i(wr3), .bus_Data_o(dout3),
        .bus_Data_e(de3), .bus_rdy_o(rdy3), .intr_o(intr3), .inta_i(1'b0)
    );

    task automatic drive(input int sel, input logic w, input logic r);
        if (sel == 1) begin wr3 = w; rd3 = r; end
        else          begin wr1 = w; rd1 = r; end
    endtask

    // One transfer; the request stays up through the rdy cycle plus 'hold' cycles
    task automatic bus_xfer(input int sel, input logic w, input logic r,
                            input logic [15:0] a, input logic [15:0] d,
                            input logic [1:0] s, input int hold,
                            output int lat, output logic [15:0] rdata,
                            output logic [15:0] rde, output int extra,
                            output logic leak);
        lat = 0; extra = 0; leak = 1'b0; rdata = '0; rde = '0;
        cur = sel;
        @(posedge clk); #1;
        addr = a; wdata = d; stb = s;
        drive(sel, w, r);
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (rdy_m) break;
            if (dout_m != 16'h0 || de_m != 16'h0) leak = 1'b1;
        end
        if (!rdy_m) lat = 99;
        rdata = dout_m;
        rde   = de_m;
        for (int i = 0; i <= hold; i++) begin
            @(posedge clk); #1;
            if (rdy_m) extra++;
            if (dout_m != 16'h0 || de_m != 16'h0) leak = 1'b1;
        end
        drive(sel, 1'b0, 1'b0);
        stb = 2'b00;
    endtask

    task automatic do_write(input int sel, input logic [15:0] a, input logic [15:0] d,
                            input logic [1:0] s, output int lat);
        logic [15:0] rd_v, re_v; int ex; logic lk;
        bus_xfer(sel, 1'b1, 1'b0, a, d, s, 0, lat, rd_v, re_v, ex, lk);
    endtask

    task automatic do_read(input int sel, input logic [15:0] a, output logic [15:0] d,
                           output logic [15:0] e, output int lat);
        int ex; logic lk;
        bus_xfer(sel, 1'b0, 1'b1, a, 16'h0, 2'b00, 0, lat, d, e, ex, lk);
    endtask

    task automatic test_reset();
        logic [15:0] d, e; int lat;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rdy1, intr1, dout1, de1} !== 34'h0) begin
            errors++; $display("FAIL reset_dut1_outputs: got %h expected 0", {rdy1, intr1, dout1, de1});
        end
        checks++;
        if ({rdy3, intr3, dout3, de3} !== 34'h0) begin
            errors++; $display("FAIL reset_dut3_outputs: got %h expected 0", {rdy3, intr3, dout3, de3});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_read(0, 16'hFF00, d, e, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h expected 0000", d); end
        do_read(0, 16'hFF08, d, e, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_presc: got %h expected 0000", d); end
    endtask

    task automatic test_write_strobes();
        logic [15:0] d, e; int lat;
        do_write(0, 16'hFF04, 16'h1234, 2'b11, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", lat); end
        do_read(0, 16'hFF04, d, e, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d expected 2", lat); end
        checks++;
        if (d !== 16'h1234) begin errors++; $display("FAIL reload_full: got %h expected 1234", d); end
        do_write(0, 16'hFF04, 16'hAB00, 2'b10, lat);
        do_read(0, 16'hFF04, d, e, lat);
        checks++;
        if (d !== 16'hAB34) begin errors++; $display("FAIL reload_hi_byte: got %h expected ab34", d); end
        do_write(0, 16'hFF04, 16'hFFFF, 2'b00, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL stb0_latency: got %0d expected 2", lat); end
        do_read(0, 16'hFF04, d, e, lat);
        checks++;
        if (d !== 16'hAB34) begin errors++; $display("FAIL stb0_no_change: got %h expected ab34", d); end
        do_write(0, 16'hFF04, 16'h00CD, 2'b01, lat);
        do_read(0, 16'hFF04, d, e, lat);
        checks++;
        if (d !== 16'hABCD) begin errors++; $display("FAIL reload_lo_byte: got %h expected abcd", d); end
    endtask

    task automatic test_read_enables();
        logic [15:0] d, e; int lat, ex; logic lk;
        do_write(0, 16'hFF06, 16'h0005, 2'b11, lat);
        bus_xfer(0, 1'b0, 1'b1, 16'hFF06, 16'h0, 2'b00, 0, lat, d, e, ex, lk);
        checks++;
        if ({d, e} !== {16'h0005, 16'hFFFF}) begin
            errors++; $display("FAIL read_count_rdy: got data %h en %h expected 0005 ffff", d, e);
        end
        checks++;
        if (lk !== 1'b0) begin errors++; $display("FAIL read_drive_outside_rdy: got %b expected 0", lk); end
        do_write(0, 16'hFF0C, 16'hBEEF, 2'b11, lat);
        do_read(0, 16'hFF0C, d, e, lat);
        checks++;
        if ({d, e} !== {16'h0000, 16'hFFFF}) begin
            errors++; $display("FAIL read_idx6: got data %h en %h expected 0000 ffff", d, e);
        end
        do_read(0, 16'hFF0A, d, e, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL read_idx5: got %h expected 0000", d); end
        do_write(0, 16'hFF00, 16'hFFF8, 2'b11, lat);
        do_read(0, 16'hFF00, d, e, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL ctrl_unused_bits: got %h expected 0000", d); end
        do_read(0, 16'hFF02, d, e, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL status_idle: got %h expected 0000", d); end
    endtask

    task automatic test_rd_wr_both();
        logic [15:0] d, e; int lat, ex; logic lk;
        bus_xfer(0, 1'b1, 1'b1, 16'hFF04, 16'h5A5A, 2'b11, 0, lat, d, e, ex, lk);
        checks++;
        if ({d, e} !== 32'h0) begin
            errors++; $display("FAIL rdwr_not_read: got data %h en %h expected 0000 0000", d, e);
        end
        do_read(0, 16'hFF04, d, e, lat);
        checks++;
        if (d !== 16'h5A5A) begin errors++; $display("FAIL rdwr_is_write: got %h expected 5a5a", d); end
    endtask

    task automatic test_abort();
        logic [15:0] d, e; int lat; logic seen;
        cur = 0; seen = 1'b0;
        @(posedge clk); #1;
        addr = 16'hFF04; wdata = 16'h0BAD; stb = 2'b11; wr1 = 1'b1;
        @(posedge clk); #1;
        wr1 = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rdy1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_rdy: got %b expected 0", seen); end
        do_read(0, 16'hFF04, d, e, lat);
        checks++;
        if (d !== 16'h5A5A) begin errors++; $display("FAIL abort_no_write: got %h expected 5a5a", d); end
    endtask

    task automatic test_oneshot();
        logic [15:0] d, e; int lat;
        do_write(0, 16'hFF08, 16'h0000, 2'b11, lat);
        do_write(0, 16'hFF06, 16'h0003, 2'b11, lat);
        do_write(0, 16'hFF00, 16'h0005, 2'b11, lat);
        // ticks on the next four edges; the fourth expires
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (intr1 !== 1'b0) begin errors++; $display("FAIL oneshot_early: got %b expected 0", intr1); end
        @(posedge clk); #1;
        checks++;
        if (intr1 !== 1'b1) begin errors++; $display("FAIL oneshot_expire: got %b expected 1", intr1); end
        do_read(0, 16'hFF00, d, e, lat);
        checks++;
        if (d !== 16'h0004) begin errors++; $display("FAIL oneshot_en_clear: got %h expected 0004", d); end
        do_read(0, 16'hFF06, d, e, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL oneshot_count_zero: got %h expected 0000", d); end
        do_read(0, 16'hFF02, d, e, lat);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL oneshot_status: got %h expected 0001", d); end
        @(posedge clk); #1;
        inta = 1'b1;
        @(posedge clk); #1;
        inta = 1'b0;
        checks++;
        if (intr1 !== 1'b0) begin errors++; $display("FAIL inta_clear: got %b expected 0", intr1); end
    endtask

    task automatic test_autoreload();
        int lat;
        do_write(0, 16'hFF08, 16'h0002, 2'b11, lat);
        do_write(0, 16'hFF04, 16'h0001, 2'b11, lat);
        do_write(0, 16'hFF06, 16'h0001, 2'b11, lat);
        do_write(0, 16'hFF00, 16'h0007, 2'b11, lat);
        // commit edge = E3; expiries expected at E9 and E15
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (intr1 !== 1'b0) begin errors++; $display("FAIL reload_early: got %b expected 0", intr1); end
        @(posedge clk); #1;
        checks++;
        if (intr1 !== 1'b1) begin errors++; $display("FAIL reload_first_expiry: got %b expected 1", intr1); end
        inta = 1'b1;
        @(posedge clk); #1;
        inta = 1'b0;
        checks++;
        if (intr1 !== 1'b0) begin errors++; $display("FAIL reload_ack: got %b expected 0", intr1); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (intr1 !== 1'b0) begin errors++; $display("FAIL reload_between: got %b expected 0", intr1); end
        inta = 1'b1;
        @(posedge clk); #1;
        inta = 1'b0;
        checks++;
        if (intr1 !== 1'b1) begin errors++; $display("FAIL set_beats_ack: got %b expected 1", intr1); end
        @(posedge clk); #1;
        checks++;
        if (intr1 !== 1'b1) begin errors++; $display("FAIL exp_sticky: got %b expected 1", intr1); end
        do_write(0, 16'hFF00, 16'h0004, 2'b11, lat);
    endtask

    task automatic test_no_double();
        logic [15:0] d, e; int lat, ex; logic lk;
        checks++;
        if (intr1 !== 1'b1) begin errors++; $display("FAIL pre_w1c_intr: got %b expected 1", intr1); end
        bus_xfer(0, 1'b1, 1'b0, 16'hFF02, 16'h0001, 2'b11, 5, lat, d, e, ex, lk);
        checks++;
        if (ex !== 0) begin errors++; $display("FAIL w1c_single_rdy: got %0d extra expected 0", ex); end
        checks++;
        if (intr1 !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b expected 0", intr1); end
        do_write(0, 16'hFF06, 16'h0064, 2'b11, lat);
        do_write(0, 16'hFF08, 16'h0000, 2'b11, lat);
        do_write(0, 16'hFF00, 16'h0001, 2'b11, lat);
        // COUNT=50 lands at E3, then decrements each edge through the CTRL=0 commit
        bus_xfer(0, 1'b1, 1'b0, 16'hFF06, 16'h0032, 2'b11, 5, lat, d, e, ex, lk);
        checks++;
        if (ex !== 0) begin errors++; $display("FAIL count_single_rdy: got %0d extra expected 0", ex); end
        do_write(0, 16'hFF00, 16'h0000, 2'b11, lat);
        do_read(0, 16'hFF06, d, e, lat);
        checks++;
        if (d !== 16'h0029) begin errors++; $display("FAIL count_write_once: got %h expected 0029", d); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, e; int lat; logic seen;
        do_write(1, 16'hFF06, 16'h0077, 2'b11, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL wait3_latency: got %0d expected 4", lat); end
        do_read(1, 16'hFF06, d, e, lat);
        checks++;
        if (d !== 16'h0077) begin errors++; $display("FAIL wait3_count: got %h expected 0077", d); end
        cur = 1; seen = 1'b0;
        @(posedge clk); #1;
        addr = 16'hFF06; wdata = 16'h1111; stb = 2'b11; wr3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; wr3 = 1'b0; stb = 2'b00;
        checks++;
        if ({rdy3, de3} !== 17'h0) begin errors++; $display("FAIL mid_reset_outputs: got %h expected 0", {rdy3, de3}); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy3) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_rdy: got %b expected 0", seen); end
        do_read(1, 16'hFF06, d, e, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL mid_reset_count: got %h expected 0000", d); end
        do_read(0, 16'hFF04, d, e, lat);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_reload_dut1: got %h expected 0000", d); end
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; wdata = '0; stb = '0;
        rd1 = 1'b0; wr1 = 1'b0; rd3 = 1'b0; wr3 = 1'b0; inta = 1'b0;
        test_reset();
        test_write_strobes();
        test_read_enables();
        test_rd_wr_both();
        test_abort();
        test_oneshot();
        test_autoreload();
        test_no_double();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dbus_timer_target.md
DBUS_TIMER_TARGET -- requirements
Module: dbus_timer_target

Interface
REQ-001 SHALL have parameter BASE, default 16'hFF00, decode base; only bits [15:4] are compared.
REQ-002 SHALL have parameter WAIT, default 1, wait cycles inserted before rdy (0..15).
REQ-003 SHALL have port clk_i  in  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bus_Addr_i  in  16  byte address from the bus master.
REQ-006 SHALL have port bus_Data_i  in  16  write data.
REQ-007 SHALL have port bus_stb_i  in  2  byte strobes; [0] selects bits 7:0 and [1] selects bits 15:8.
REQ-008 SHALL have ports bus_rd_i and bus_wr_i  in  1 each  read or write request, held until rdy is seen.
REQ-009 SHALL have port bus_Data_o  out  16  read data.
REQ-010 SHALL have port bus_Data_e  out  16  per-bit output enable for bus_Data_o.
REQ-011 SHALL have port bus_rdy_o  out  1  transfer-complete strobe.
REQ-012 SHALL have port intr_o  out  1  maskable interrupt request.
REQ-013 SHALL have port inta_i  in  1  interrupt acknowledge pulse.

Function
REQ-014 SHALL select the block when bus_Addr_i[15:4]==BASE[15:4] and (bus_rd_i|bus_wr_i); the register index is bus_Addr_i[3:1].
REQ-015 SHALL implement this register map:
- 0 CTRL[2:0] = {IE, AR, EN}, read/write.
- 1 STATUS[0] = EXP; reads EXP; a write of 1 clears EXP.
- 2 RELOAD[15:0], read/write.
- 3 COUNT[15:0], read/write.
- 4 PRESC[15:0], read/write.
- Indices 5-7 read 0 and ignore writes.
- Unused bits read 0.
REQ-016 SHALL apply writes only to the bytes enabled by bus_stb_i; a write with stb==2'b00 completes with no register change.
REQ-017 SHALL run the bus FSM through these states:
- IDLE: on select, load the wait counter with WAIT; go to WAIT, or go to RESP if WAIT==0.
- WAIT: decrement the counter; go to RESP when it is 0.
- RESP: assert bus_rdy_o for exactly this one cycle; commit the write or drive the read data; go to HOLD.
- HOLD: go to IDLE once bus_rd_i and bus_wr_i are both low.
REQ-018 SHALL give a transfer latency of WAIT+1 cycles from first select to bus_rdy_o.
REQ-019 SHALL drive read data only in RESP of a read: bus_Data_e=16'hFFFF and bus_Data_o=register value.
REQ-020 SHALL hold bus_Data_e=0 and bus_Data_o=0 in every other cycle.
REQ-021 SHALL treat a request with rd and wr both high as a write; it SHALL be treated as a read for neither.
REQ-022 SHALL abort to IDLE without rdy and without a write if rd and wr both drop during WAIT.
REQ-023 SHALL tick the prescaler as follows while EN=1:
- The prescaler down-counter counts from PRESC to 0; the tick is the cycle it is 0.
- It reloads with PRESC on the cycle after a tick.
- PRESC=0 means a tick every cycle.
REQ-024 SHALL, on each tick:
- COUNT!=0: decrement COUNT.
- COUNT==0: set EXP.
- COUNT==0 with AR=1: load COUNT with RELOAD.
- COUNT==0 with AR=0: clear EN and hold COUNT at 0.
REQ-025 SHALL give a bus write to COUNT priority over a same-cycle tick decrement or reload.
REQ-026 SHALL reset the prescaler to PRESC on a bus write to PRESC or CTRL.
REQ-027 SHALL drive intr_o = EXP & IE, registered-free and combinational from the flops.
REQ-028 SHALL clear EXP on inta_i=1 or on a STATUS write of bit0=1.
REQ-029 SHALL let a same-cycle expiry set win over any clear of EXP.
REQ-030 SHALL freeze the counter and prescaler while EN=0.

Reset
REQ-031 SHALL, while rst_i=0, force:
- FSM to IDLE.
- CTRL=0 and EXP=0.
- RELOAD=0, COUNT=0, PRESC=0, prescaler=0.
- bus_rdy_o=0, bus_Data_o=0, bus_Data_e=0, intr_o=0.
REQ-032 SHALL abandon a transfer in progress when reset asserts, with no rdy and no write after release.
REQ-033 SHALL resume normal operation on the first rising clk_i edge after rst_i returns high.

Verification
REQ-034 SHALL pass a directed test on write latency and strobes:
- Stimulus: WAIT=1; write 16'h1234 to FF04 with stb=2'b11.
- Response: rdy 2 cycles after request; RELOAD=1234.
- Stimulus: write 16'hAB00 with stb=2'b10.
- Response: RELOAD=AB34.
REQ-035 SHALL pass a directed test on read data and enables:
- Stimulus: read FF06 with COUNT=0005.
- Response: bus_Data_o=0005 and bus_Data_e=FFFF in the rdy cycle only; both 0 otherwise.
REQ-036 SHALL pass a directed test on one-shot expiry:
- Stimulus: PRESC=0, COUNT=3, CTRL=3'b101.
- Response: EXP=1 and intr_o=1 on the 4th tick; EN=0; COUNT stays 0.
- Stimulus: pulse inta_i.
- Response: intr_o=0.
REQ-037 SHALL pass a directed test on auto-reload with prescale:
- Stimulus: PRESC=2, RELOAD=1, COUNT=1, CTRL=3'b011.
- Response: expiry every 6 cycles.
- Stimulus: expiry coincident with inta_i.
- Response: EXP stays 1.
REQ-038 SHALL pass a directed test on reset mid-transfer:
- Stimulus: WAIT=3; start a write to COUNT; assert rst_i in WAIT; release.
- Response: no rdy; COUNT=0.
REQ-039 SHALL pass a directed test on no double execution:
- Stimulus: hold bus_wr_i after rdy.
- Response: exactly one rdy pulse; a write-1-clear of STATUS executes once.
